mi_arbiter: RTL
===============

Name: mi_arbiter

Overview:
- Shares the single qpi_memctrl memory interface (mi_*) between N_REQ requesters, e.g. memtest plus an LCD framebuffer fetcher.
- Round-robin arbitration; a grant is held for one full command plus its data burst, then released.
- Sits between the requesters and qpi_memctrl in the clk_1x domain.
- Pure sequencing and muxing: it does not buffer data and does not modify address or length.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- AW, 32, mi address width.

Ports:
- clk  in  1  system clock (clk_1x)
- rst_n  in  1  synchronous active-low reset
- r_addr  in  N_REQ*AW  per-requester address, requester i at [i*AW+:AW]
- r_len  in  N_REQ*7  per-requester burst length (words-1)
- r_rw  in  N_REQ  per-requester direction, 1=read 0=write
- r_valid  in  N_REQ  per-requester command valid
- r_ready  out  N_REQ  per-requester command accept
- r_wdata  in  N_REQ*32  per-requester write data
- r_wack  out  N_REQ  write data accepted, granted requester only
- r_wlast  out  N_REQ  last write word, granted requester only
- r_rdata  out  32  read data, broadcast to all requesters
- r_rstb  out  N_REQ  read data strobe, granted requester only
- r_rlast  out  N_REQ  last read word, granted requester only
- mi_addr, mi_len, mi_rw, mi_valid  out  AW,7,1,1  to controller
- mi_ready  in  1  from controller
- mi_wdata  out  32  to controller
- mi_wack, mi_wlast  in  1,1  from controller
- mi_rdata  in  32  from controller
- mi_rstb, mi_rlast  in  1,1  from controller
- grant  out  N_REQ  one-hot current owner, 0 when idle
- busy  out  1  grant held

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, grant=0, busy=0, rr pointer=0.
  - All r_ready/r_wack/r_wlast/r_rstb/r_rlast=0, mi_valid=0.
  - Reset mid-burst aborts the grant without waiting for last. The controller shares the same reset.
- States: IDLE -> CMD -> DATA -> IDLE.
- IDLE:
  - If any r_valid is high, select the first requester at or after the rr pointer (wrapping modulo N_REQ).
  - Register the grant and go to CMD. Latency: r_valid seen at edge t gives mi_valid=1 in cycle t+1.
  - If no r_valid is high, stay in IDLE.
- CMD:
  - mi_addr/mi_len/mi_rw/mi_valid come combinationally from the granted requester.
  - r_ready[g] = mi_ready; all other r_ready are 0.
  - On mi_valid & mi_ready, latch rw, move to DATA and set rr pointer = g+1 (mod N_REQ).
  - If the granted requester drops r_valid before acceptance (protocol violation), return to IDLE next cycle with the rr pointer unchanged.
- DATA:
  - Write: mi_wdata=r_wdata[g]; r_wack[g]=mi_wack; r_wlast[g]=mi_wlast. Exit when mi_wack & mi_wlast.
  - Read: r_rstb[g]=mi_rstb; r_rlast[g]=mi_rlast. Exit when mi_rstb & mi_rlast.
  - Last cannot coincide with command acceptance, so data tracking starts the cycle after acceptance.
  - Exit goes to IDLE, dropping grant in the next cycle. This gives one bubble cycle minimum between bursts.
- Outside DATA, and for non-granted requesters, all wack/wlast/rstb/rlast outputs are forced to 0.
- mi_* outputs are 0 while IDLE. mi_wdata is 0 when no write is in progress.
- busy=1 in CMD and DATA.
- Simultaneous requests: round-robin order only; no starvation. Each requester is served within N_REQ grants.
- Lengths pass through unchanged; len=0 means a single-word burst with wlast/rlast on the first word.

Optional Feature:
- Macro: MI_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The rr pointer is removed and selection in IDLE is the lowest set r_valid bit.
- Undefined: round-robin as described above.

Test Plan:
- Single requester 0 writes addr 0x100, len 3 (4 words) -> mi_valid high one cycle after r_valid. mi_addr=0x100, mi_len=3. Four r_wack[0] pulses, last with r_wlast[0]; grant returns to 0.
- Both requesters valid at the same edge after reset (pointer 0) -> order 0,1,0,1 across 4 back-to-back bursts. At least one idle cycle between each.
- Requester 1 reads len 0 while requester 0 idles -> one r_rstb[1] with r_rlast[1] and r_rdata=mi_rdata. r_rstb[0] stays 0 throughout.
- Requester 0 write in DATA, requester 1 asserts r_valid mid-burst -> r_ready[1] stays 0 until requester 0's wlast. Requester 1 is granted on the following IDLE pass.
- rst_n=0 for one cycle during a read burst of len 7 after the 3rd rstb -> next cycle grant=0, busy=0, mi_valid=0. Later rstb pulses are not forwarded.
- With MI_ARBITER_FIXED_PRIO_EN defined and both requesters permanently valid -> requester 0 is granted on every burst.

Source files
------------

// File: rtl/mi_arbiter.sv
// Round-robin arbiter sharing one qpi_memctrl mi_* port between N_REQ requesters.
// Define MI_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead.
module mi_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ*AW-1:0] r_addr,
  input  logic [N_REQ*7-1:0]  r_len,
  input  logic [N_REQ-1:0]    r_rw,
  input  logic [N_REQ-1:0]    r_valid,
  output logic [N_REQ-1:0]    r_ready,
  input  logic [N_REQ*32-1:0] r_wdata,
  output logic [N_REQ-1:0]    r_wack,
  output logic [N_REQ-1:0]    r_wlast,
  output logic [31:0]         r_rdata,
  output logic [N_REQ-1:0]    r_rstb,
  output logic [N_REQ-1:0]    r_rlast,
  output logic [AW-1:0]       mi_addr,
  output logic [6:0]          mi_len,
  output logic                mi_rw,
  output logic                mi_valid,
  input  logic                mi_ready,
  output logic [31:0]         mi_wdata,
  input  logic                mi_wack,
  input  logic                mi_wlast,
  input  logic [31:0]         mi_rdata,
  input  logic                mi_rstb,
  input  logic                mi_rlast,
  output logic [N_REQ-1:0]    grant,
  output logic                busy
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic          rw_q, rw_d;
`ifndef MI_ARBITER_FIXED_PRIO_EN
  logic [IW-1:0] rr_q, rr_d;
`endif

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [AW-1:0] g_addr;
  logic [6:0]    g_len;
  logic          g_rw;
  logic          g_valid;
  logic [31:0]   g_wdata;

  // Walk offsets downward so the last hit is the nearest one to the start point.
  always_comb begin
    logic [IW-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef MI_ARBITER_FIXED_PRIO_EN
      idx = IW'(k);
`else
      idx = IW'((int'(rr_q) + k) % N_REQ);
`endif
      if (r_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  always_comb begin
    g_addr  = '0;
    g_len   = '0;
    g_rw    = 1'b0;
    g_valid = 1'b0;
    g_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_q == IW'(i)) begin
        g_addr  = r_addr[i*AW +: AW];
        g_len   = r_len[i*7 +: 7];
        g_rw    = r_rw[i];
        g_valid = r_valid[i];
        g_wdata = r_wdata[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    rw_d    = rw_q;
`ifndef MI_ARBITER_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d = StCmd;
          gidx_d  = sel_idx;
        end
      end
      StCmd: begin
        if (!g_valid) begin
          state_d = StIdle;
        end else if (mi_ready) begin
          state_d = StData;
          rw_d    = g_rw;
`ifndef MI_ARBITER_FIXED_PRIO_EN
          rr_d    = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
`endif
        end
      end
      StData: begin
        if (rw_q ? (mi_rstb && mi_rlast) : (mi_wack && mi_wlast)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mi_addr  = '0;
    mi_len   = '0;
    mi_rw    = 1'b0;
    mi_valid = 1'b0;
    mi_wdata = '0;
    r_ready  = '0;
    r_wack   = '0;
    r_wlast  = '0;
    r_rstb   = '0;
    r_rlast  = '0;
    r_rdata  = mi_rdata;
    busy     = (state_q != StIdle);
    grant    = busy ? (N_REQ'(1) << gidx_q) : '0;
    case (state_q)
      StCmd: begin
        mi_addr         = g_addr;
        mi_len          = g_len;
        mi_rw           = g_rw;
        mi_valid        = g_valid;
        r_ready[gidx_q] = mi_ready;
      end
      StData: begin
        if (rw_q) begin
          r_rstb[gidx_q]  = mi_rstb;
          r_rlast[gidx_q] = mi_rlast;
        end else begin
          mi_wdata        = g_wdata;
          r_wack[gidx_q]  = mi_wack;
          r_wlast[gidx_q] = mi_wlast;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gidx_q  <= '0;
      rw_q    <= 1'b0;
`ifndef MI_ARBITER_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      rw_q    <= rw_d;
`ifndef MI_ARBITER_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule
